buf_dma_ctrl: RTL and testbench

- Host-side end of the accelerator source/destination buffer interface.
- LOAD: accepts a 64-bit input stream and writes it into the source buffer as src_v/src_a/src_d0..3 write beats.
- UNLOAD: issues dst_v/dst_a reads to the destination buffer, captures dst_d0/dst_d1 one cycle later and emits them as a 64-bit output stream with backpressure.
- One command executes at a time; completion is reported by a done pulse.

---
 rtl/buf_dma_pkg.sv | 41 ++++
 rtl/buf_dma_skid.sv | 55 +++++
 rtl/buf_dma_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_buf_dma_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_dma_pkg.sv
// Shared definitions for the buffer DMA controller.
// Holds the controller state encoding, the buffer index and address widths,
// and helpers that pack a bank bit and word index into a 13-bit source or
// destination buffer address.
package buf_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    localparam int SRC_IDX_W = 10;
    localparam int DST_IDX_W = 11;
    localparam int ADDR_W    = 13;
    localparam int BANK_BIT  = 12;
    // Skid FIFO entry: {last_flag, dst_d1, dst_d0}
    localparam int FIFO_W    = 65;

    // {bank, 2'b00, idx[9:0]}
    function automatic logic [ADDR_W-1:0] pack_src_addr(input logic bank,
                                                        input logic [SRC_IDX_W-1:0] idx);
        logic [ADDR_W-1:0] addr;
        addr = '0;
        addr[BANK_BIT] = bank;
        addr[SRC_IDX_W-1:0] = idx;
        return addr;
    endfunction

    // {bank, 1'b0, idx[10:0]}
    function automatic logic [ADDR_W-1:0] pack_dst_addr(input logic bank,
                                                        input logic [DST_IDX_W-1:0] idx);
        logic [ADDR_W-1:0] addr;
        addr = '0;
        addr[BANK_BIT] = bank;
        addr[DST_IDX_W-1:0] = idx;
        return addr;
    endfunction

endpackage

// File: rtl/buf_dma_skid.sv
// Two-entry skid FIFO holding destination read data on its way to the
// output stream.
// Ports: clk, rst_n (async active-low), push/push_data (write side),
// pop (read side, only when count != 0), head (oldest entry), count (0..2).
module buf_dma_skid
    import buf_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [FIFO_W-1:0] push_data,
    input  logic              pop,
    output logic [FIFO_W-1:0] head,
    output logic [1:0]        count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [FIFO_W-1:0] entry_reg;
            // Entries reset to zero so the output data bus reads 0 after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign count = count_reg;

endmodule

// File: rtl/buf_dma_ctrl.sv
// Host-side end of the accelerator source/destination buffer interface.
// LOAD copies a 64-bit input stream into the source buffer (one write beat
// per accepted word); UNLOAD reads the destination buffer and streams the
// words out through a 2-entry skid FIFO with backpressure. One command runs
// at a time and completion is signalled by a one-cycle done pulse.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_v/cmd_rdy/cmd_dir/cmd_bank/cmd_len   command handshake and fields
//   busy, done                     status (done = 1-cycle completion pulse)
//   s_valid/s_ready/s_data         64-bit input stream (LOAD)
//   m_valid/m_ready/m_data/m_last  64-bit output stream (UNLOAD)
//   src_v/src_a/src_d0..src_d3     source buffer write port
//   dst_v/dst_a/dst_d0/dst_d1      destination buffer read port (1-cycle latency)
// Optional: define BUF_DMA_STALL_CNT_EN to add the 32-bit stall_cnt output,
// a saturating count of stream stall cycles cleared on command accept.
module buf_dma_ctrl
    import buf_dma_pkg::*;
#(
    parameter int SRC_DEPTH = 1024,
    parameter int DST_DEPTH = 2048,
    parameter int LEN_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_v,
    output logic              cmd_rdy,
    input  logic              cmd_dir,
    input  logic              cmd_bank,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [63:0]       s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [63:0]       m_data,
    output logic              m_last,
    output logic              src_v,
    output logic [ADDR_W-1:0] src_a,
    output logic [15:0]       src_d0,
    output logic [15:0]       src_d1,
    output logic [15:0]       src_d2,
    output logic [15:0]       src_d3,
    output logic              dst_v,
    output logic [ADDR_W-1:0] dst_a,
    input  logic [31:0]       dst_d0,
    input  logic [31:0]       dst_d1
`ifdef BUF_DMA_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t             state_reg, state_next;
    logic               bank_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   idx_reg;
    logic [LEN_W-1:0]   eff_len;
    logic               src_v_reg;
    logic [ADDR_W-1:0]  src_a_reg;
    logic [ADDR_W-1:0]  dst_a_reg;
    logic               inflight_reg;
    logic               inflight_last_reg;
    logic               load_fire;
    logic               issue;
    logic               pop;
    logic [1:0]         occupancy;
    logic [FIFO_W-1:0]  fifo_head;
    logic [1:0]         fifo_count;

    // Clamp the requested length to the depth of the addressed buffer.
    always_comb begin
        eff_len = cmd_len;
        if (cmd_dir) begin
            if (cmd_len > LEN_W'(DST_DEPTH)) eff_len = LEN_W'(DST_DEPTH);
        end else begin
            if (cmd_len > LEN_W'(SRC_DEPTH)) eff_len = LEN_W'(SRC_DEPTH);
        end
    end

    assign load_fire = s_valid && s_ready;
    assign m_valid   = (fifo_count != 2'd0);
    assign pop       = m_valid && m_ready;
    assign occupancy = fifo_count + {1'b0, inflight_reg};

    always_comb begin
        state_next = state_reg;
        cmd_rdy    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        s_ready    = 1'b0;
        issue      = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
                if (cmd_v) begin
                    if (eff_len == '0)  state_next = ST_FIN;
                    else if (cmd_dir)   state_next = ST_UNLOAD;
                    else                state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = (idx_reg < len_reg);
                // idx reaches len in the cycle the final write beat is on src_v.
                if (idx_reg == len_reg) state_next = ST_FIN;
            end
            ST_UNLOAD: begin
                // A pop this cycle frees a slot before the in-flight word lands,
                // which is what sustains one read per clock.
                issue = (idx_reg < len_reg) &&
                        ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
                if (pop && fifo_head[FIFO_W-1]) state_next = ST_FIN;
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            bank_reg          <= 1'b0;
            len_reg           <= '0;
            idx_reg           <= '0;
            src_v_reg         <= 1'b0;
            src_a_reg         <= '0;
            dst_a_reg         <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            src_v_reg         <= load_fire;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (idx_reg == len_reg - ONE);
            if ((state_reg == ST_IDLE) && cmd_v) begin
                bank_reg <= cmd_bank;
                len_reg  <= eff_len;
                idx_reg  <= '0;
            end else if (load_fire || issue) begin
                idx_reg <= idx_reg + ONE;
            end
            if (load_fire) src_a_reg <= pack_src_addr(bank_reg, idx_reg[SRC_IDX_W-1:0]);
            if (issue)     dst_a_reg <= pack_dst_addr(bank_reg, idx_reg[DST_IDX_W-1:0]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (load_fire) begin
                    lane_reg <= s_data[gi*16 +: 16];
                end
            end
        end
    endgenerate

    assign src_v  = src_v_reg;
    assign src_a  = src_a_reg;
    assign src_d0 = g_lane[0].lane_reg;
    assign src_d1 = g_lane[1].lane_reg;
    assign src_d2 = g_lane[2].lane_reg;
    assign src_d3 = g_lane[3].lane_reg;

    // dst_a only moves when a read is issued, so the buffer's bank-select
    // mux stays stable until the previous word has been captured.
    assign dst_v = issue;
    assign dst_a = issue ? pack_dst_addr(bank_reg, idx_reg[DST_IDX_W-1:0]) : dst_a_reg;

    buf_dma_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data ({inflight_last_reg, dst_d1, dst_d0}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign m_data = fifo_head[63:0];
    assign m_last = m_valid && fifo_head[FIFO_W-1];

`ifdef BUF_DMA_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic        stall_hit;

    assign stall_hit = ((state_reg == ST_LOAD)   && s_ready && !s_valid) ||
                       ((state_reg == ST_UNLOAD) && m_valid && !m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_IDLE) && cmd_v) begin
            stall_cnt_reg <= '0;
        end else if (stall_hit && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_buf_dma_ctrl.sv
// Directed testbench for buf_dma_ctrl: LOAD and UNLOAD transfers, stream
// backpressure, zero and over-long lengths, and reset during a transfer.
// Inputs are driven just after the falling edge and outputs are checked 1
// time unit later, so every check sees the state left by the previous rising
// edge together with the inputs about to be sampled by the next one.
module tb_buf_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_v, cmd_rdy, cmd_dir, cmd_bank;
    logic [11:0] cmd_len;
    logic        busy, done;
    logic        s_valid, s_ready;
    logic [63:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [63:0] m_data;
    logic        src_v, dst_v;
    logic [12:0] src_a, dst_a;
    logic [15:0] src_d0, src_d1, src_d2, src_d3;
    logic [31:0] dst_d0 = 32'd0;
    logic [31:0] dst_d1 = 32'd0;
`ifdef BUF_DMA_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    buf_dma_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_v(cmd_v), .cmd_rdy(cmd_rdy), .cmd_dir(cmd_dir), .cmd_bank(cmd_bank), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .src_v(src_v), .src_a(src_a), .src_d0(src_d0), .src_d1(src_d1), .src_d2(src_d2), .src_d3(src_d3),
        .dst_v(dst_v), .dst_a(dst_a), .dst_d0(dst_d0), .dst_d1(dst_d1)
`ifdef BUF_DMA_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Destination buffer model: synchronous read, data = address in the low
    // word and address tagged with 0xD in the high word.
    always @(posedge clk) begin
        if (dst_v) begin
            dst_d0 <= {19'd0, dst_a};
            dst_d1 <= 32'hD000_0000 | {19'd0, dst_a};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one command for one cycle; returns at the falling edge of the
    // first cycle after acceptance.
    task automatic send_cmd(input logic dir, input logic bank, input logic [11:0] len);
        @(negedge clk);
        s_valid  = 1'b0;
        cmd_v    = 1'b1;
        cmd_dir  = dir;
        cmd_bank = bank;
        cmd_len  = len;
        #1;
        chk("cmd_rdy_at_accept", cmd_rdy, 1);
        $display("cmd: dir=%0d bank=%0d len=%0d", dir, bank, len);
        @(negedge clk);
        cmd_v = 1'b0;
    endtask

    // UNLOAD with a scoreboard: data order, last flag, outstanding reads
    // (FIFO + in flight) never above 2, no read issued into a full FIFO.
    task automatic run_unload(input logic bank, input int len, input int stall_at, input int stall_n);
        int  issued;
        int  popped;
        int  max_out;
        bit  seen_done;
        logic [31:0] addr;
        issued = 0; popped = 0; max_out = 0; seen_done = 1'b0;
        send_cmd(1'b1, bank, 12'(len));
        for (int c = 0; c < 60 && !seen_done; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = !((c >= stall_at) && (c < stall_at + stall_n));
            #1;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if ((issued - popped == 2) && !m_ready) chk("unl_no_read_when_full", dst_v, 0);
                if (dst_v) begin
                    chk("unl_dst_a", dst_a, {bank, 1'b0, 11'(issued)});
                    issued++;
                end
                if (m_valid && m_ready) begin
                    addr = 32'(popped) | (bank ? 32'h1000 : 32'h0);
                    chk("unl_data", m_data, {32'hD000_0000 | addr, addr});
                    chk("unl_last", m_last, (popped == len - 1));
                    popped++;
                end
                if (issued - popped > max_out) max_out = issued - popped;
            end
        end
        chk("unl_done_seen", seen_done, 1);
        chk("unl_words", popped, len);
        chk("unl_reads", issued, len);
        chk("unl_outstanding_le2", (max_out <= 2), 1);
        @(negedge clk);
        #1;
        chk("unl_done_one_cycle", done, 0);
        chk("unl_idle_rdy", cmd_rdy, 1);
    endtask

    initial begin
        int          writes;
        logic [12:0] last_a;
        bit          seen_done;

        rst_n = 1'b0; cmd_v = 1'b0; cmd_dir = 1'b0; cmd_bank = 1'b0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_src_v", src_v, 0);
        chk("rst_dst_v", dst_v, 0);
        chk("rst_src_a", src_a, 0);
        chk("rst_dst_a", dst_a, 0);
        chk("rst_src_d0", src_d0, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD bank0 len=4, stream valid every cycle.
        send_cmd(1'b0, 1'b0, 12'd4);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            s_valid = 1'b1;
            s_data  = 64'h0004_0003_0002_0001 + 64'(k) * 64'h0001_0001_0001_0001;
            #1;
            chk("l1_s_ready", s_ready, (k < 4));
            chk("l1_src_v", src_v, (k >= 1 && k <= 4));
            chk("l1_done", done, (k == 5));
            if (k >= 1 && k <= 4) begin
                chk("l1_src_a", src_a, 13'(k - 1));
                chk("l1_src_d0", src_d0, 16'(k));
                chk("l1_src_d3", src_d3, 16'(k + 3));
            end
        end
        chk("l1_cmd_rdy_after", cmd_rdy, 1);

        // LOAD bank1 len=3, s_valid on every other cycle.
        send_cmd(1'b0, 1'b1, 12'd3);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(negedge clk);
            s_valid = ((k % 2) == 0);
            s_data  = 64'hAAAA_BBBB_CCCC_0000 + 64'(k / 2);
            #1;
            chk("l2_src_v", src_v, ((k % 2) == 1) && (k <= 5));
            chk("l2_s_ready", s_ready, (k < 5));
            chk("l2_done", done, (k == 6));
            if (((k % 2) == 1) && (k <= 5)) begin
                chk("l2_src_a", src_a, 13'h1000 + 13'((k - 1) / 2));
                chk("l2_src_d0", src_d0, 16'((k - 1) / 2));
                chk("l2_src_d3", src_d3, 16'hAAAA);
            end
        end
        s_valid = 1'b0;

        // UNLOAD bank1 len=5, no backpressure: cycle-exact timing.
        send_cmd(1'b1, 1'b1, 12'd5);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = 1'b1;
            #1;
            chk("u1_dst_v", dst_v, (c < 5));
            chk("u1_dst_a", dst_a, 13'h1000 + 13'((c < 5) ? c : 4));
            chk("u1_m_valid", m_valid, (c >= 2 && c <= 6));
            chk("u1_m_last", m_last, (c == 6));
            chk("u1_done", done, (c == 7));
            if (c >= 2 && c <= 6)
                chk("u1_m_data", m_data, {32'hD000_1000 + 32'(c - 2), 32'h1000 + 32'(c - 2)});
        end
        chk("u1_cmd_rdy_after", cmd_rdy, 1);

        // UNLOAD bank0 len=6 with m_ready low for 4 cycles mid-stream.
        run_unload(1'b0, 6, 4, 4);

        // Zero-length commands complete without touching the buffers.
        send_cmd(1'b0, 1'b0, 12'd0);
        #1;
        chk("z_load_done", done, 1);
        chk("z_load_src_v", src_v, 0);
        chk("z_load_s_ready", s_ready, 0);
        @(negedge clk);
        #1;
        chk("z_load_done_end", done, 0);
        send_cmd(1'b1, 1'b1, 12'd0);
        #1;
        chk("z_unl_done", done, 1);
        chk("z_unl_dst_v", dst_v, 0);

        // Over-long LOAD is clamped to the source depth.
        send_cmd(1'b0, 1'b0, 12'hFFF);
        writes = 0; last_a = '0; seen_done = 1'b0;
        for (int c = 0; c < 1100 && !seen_done; c++) begin
            if (c > 0) @(negedge clk);
            s_valid = 1'b1;
            s_data  = 64'(c);
            #1;
            if (src_v) begin
                writes++;
                last_a = src_a;
            end
            if (done) seen_done = 1'b1;
        end
        s_valid = 1'b0;
        $display("long load: %0d writes", writes);
        chk("long_done_seen", seen_done, 1);
        chk("long_writes", writes, 1024);
        chk("long_last_a", last_a, 13'h03FF);

        // Reset in the middle of an UNLOAD, then a clean short UNLOAD.
        send_cmd(1'b1, 1'b1, 12'd5);
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = 1'b1;
        end
        #1;
        chk("r_word2_valid", m_valid, 1);
        chk("r_word2_data", m_data[31:0], 32'h1001);
        rst_n = 1'b0;
        #1;
        chk("r_dst_v", dst_v, 0);
        chk("r_dst_a", dst_a, 0);
        chk("r_m_valid", m_valid, 0);
        chk("r_m_data", m_data, 0);
        chk("r_m_last", m_last, 0);
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("r_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("r_no_done_release", done, 0);
        run_unload(1'b0, 2, 100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
